// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding and its width.
package mem_arbiter_pkg;

    localparam int unsigned STATE_BITS = 2;

    typedef enum logic [STATE_BITS-1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/mem_arbiter_rr_select.sv
// rr_select: combinational round-robin picker.
// Scans pending_i starting at pointer_i (wrapping) and returns the first pending
// port as both a one-hot grant and a binary index. All-zero grant when nothing pends.
//   pending_i  in  PORTS   per-port pending flags
//   pointer_i  in  IDX_W   highest-priority port for this pick
//   grant_o    out PORTS   one-hot winner
//   index_o    out IDX_W   winner index
module rr_select #(
    parameter  int unsigned PORT_BITS = 1,
    localparam int unsigned PORTS     = 1 << PORT_BITS,
    localparam int unsigned IDX_W     = (PORT_BITS > 0) ? PORT_BITS : 1
) (
    input  logic [PORTS-1:0] pending_i,
    input  logic [IDX_W-1:0] pointer_i,
    output logic [PORTS-1:0] grant_o,
    output logic [IDX_W-1:0] index_o
);

    // First pending port at or after the pointer; index arithmetic wraps mod PORTS.
    always_comb begin
        logic [IDX_W-1:0] cand;
        logic             found;
        cand    = '0;
        found   = 1'b0;
        grant_o = '0;
        index_o = '0;
        for (int unsigned k = 0; k < PORTS; k++) begin
            cand = pointer_i + IDX_W'(k);
            if (!found && pending_i[cand]) begin
                found         = 1'b1;
                index_o       = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port among 2^PORT_BITS cache memory-side ports.
// Each port behaves like a private memory: a one-cycle re/we pulse while ready is
// high is latched into that port's slot; slots are granted round-robin and
// serialised onto the shared memory one transaction at a time.
// Build option: define MEM_ARBITER_FIXED_PRIORITY_EN for fixed lowest-index-wins
// priority (pointer held at 0); default is round-robin.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   addr, din             per-port address / write data (packed, port i at slice i)
//   re, we                per-port read / write pulses (read wins if both)
//   dout, ready           per-port read data (holds last read) / ready (registered)
//   maddr, mout, mre, mwe shared memory request (registered)
//   min, mready           shared memory read data / ready-done
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter  int unsigned ADDR_WIDTH = 64,
    parameter  int unsigned WORD_WIDTH = 64,
    parameter  int unsigned PORT_BITS  = 1,
    localparam int unsigned PORTS      = 1 << PORT_BITS,
    localparam int unsigned IDX_W      = (PORT_BITS > 0) ? PORT_BITS : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*ADDR_WIDTH-1:0] addr,
    input  logic [PORTS*WORD_WIDTH-1:0] din,
    output logic [PORTS*WORD_WIDTH-1:0] dout,
    input  logic [PORTS-1:0]            re,
    input  logic [PORTS-1:0]            we,
    output logic [PORTS-1:0]            ready,
    output logic [ADDR_WIDTH-1:0]       maddr,
    output logic [WORD_WIDTH-1:0]       mout,
    input  logic [WORD_WIDTH-1:0]       min,
    output logic                        mre,
    output logic                        mwe,
    input  logic                        mready
);

    state_e                  state_q, state_d;

    logic [PORTS-1:0]        pending_q, ready_q, slot_rd_q;
    logic [ADDR_WIDTH-1:0]   slot_addr_q [PORTS];
    logic [WORD_WIDTH-1:0]   slot_data_q [PORTS];

    logic [PORTS-1:0]        accept_c, sel_grant_c, dout_we_c;
    logic [IDX_W-1:0]        sel_idx_c;
    logic                    issue_c, done_c;

    logic [IDX_W-1:0]        win_q, win_d, ptr_q, ptr_d;
    logic [PORTS-1:0]        win_oh_q, win_oh_d;
    logic                    op_rd_q, op_rd_d;
    logic                    mre_q, mre_d, mwe_q, mwe_d;
    logic [ADDR_WIDTH-1:0]   maddr_q, maddr_d;
    logic [WORD_WIDTH-1:0]   mout_q, mout_d;
    logic [WORD_WIDTH-1:0]   dout_q [PORTS];

    rr_select #(.PORT_BITS(PORT_BITS)) u_rr_select (
        .pending_i (pending_q),
        .pointer_i (ptr_q),
        .grant_o   (sel_grant_c),
        .index_o   (sel_idx_c)
    );

    assign accept_c = (re | we) & ready_q;
    assign issue_c  = (state_q == ST_IDLE) && mready && (|sel_grant_c);
    // mre/mwe are still high during the first WAIT cycle, so the memory's
    // pre-request ready level must not be taken as completion.
    assign done_c   = (state_q == ST_WAIT) && mready && !mre_q && !mwe_q;

    // Per-port request slots: latch on accept, release on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            ready_q   <= '1;
            slot_rd_q <= '0;
            for (int unsigned i = 0; i < PORTS; i++) begin
                slot_addr_q[i] <= '0;
                slot_data_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                if (accept_c[i]) begin
                    slot_addr_q[i] <= addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    slot_data_q[i] <= din[i*WORD_WIDTH +: WORD_WIDTH];
                    slot_rd_q[i]   <= re[i];
                    pending_q[i]   <= 1'b1;
                    ready_q[i]     <= 1'b0;
                end else if (done_c && win_oh_q[i]) begin
                    pending_q[i]   <= 1'b0;
                    ready_q[i]     <= 1'b1;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (issue_c) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (done_c) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: next values for the memory-side and response registers.
    always_comb begin
        win_d     = win_q;
        win_oh_d  = win_oh_q;
        op_rd_d   = op_rd_q;
        maddr_d   = maddr_q;
        mout_d    = mout_q;
        ptr_d     = ptr_q;
        mre_d     = 1'b0;
        mwe_d     = 1'b0;
        dout_we_c = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (issue_c) begin
                    win_d    = sel_idx_c;
                    win_oh_d = sel_grant_c;
                    op_rd_d  = slot_rd_q[sel_idx_c];
                    maddr_d  = slot_addr_q[sel_idx_c];
                    mout_d   = slot_data_q[sel_idx_c];
                end
            end
            ST_ISSUE: begin
                mre_d = op_rd_q;
                mwe_d = !op_rd_q;
            end
            ST_WAIT: begin
                if (done_c) begin
                    dout_we_c = win_oh_q & {PORTS{op_rd_q}};
`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
                    ptr_d = '0;
`else
                    ptr_d = (PORTS > 1) ? IDX_W'(win_q + IDX_W'(1)) : '0;
`endif
                end
            end
            default: ;
        endcase
    end

    // Memory-side, arbitration and read-data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q    <= '0;
            win_oh_q <= '0;
            op_rd_q  <= 1'b0;
            maddr_q  <= '0;
            mout_q   <= '0;
            mre_q    <= 1'b0;
            mwe_q    <= 1'b0;
            ptr_q    <= '0;
            for (int unsigned i = 0; i < PORTS; i++) begin
                dout_q[i] <= '0;
            end
        end else begin
            win_q    <= win_d;
            win_oh_q <= win_oh_d;
            op_rd_q  <= op_rd_d;
            maddr_q  <= maddr_d;
            mout_q   <= mout_d;
            mre_q    <= mre_d;
            mwe_q    <= mwe_d;
            ptr_q    <= ptr_d;
            for (int unsigned i = 0; i < PORTS; i++) begin
                if (dout_we_c[i]) dout_q[i] <= min;
            end
        end
    end

    for (genvar g = 0; g < PORTS; g++) begin : g_dout
        assign dout[g*WORD_WIDTH +: WORD_WIDTH] = dout_q[g];
    end

    assign ready = ready_q;
    assign maddr = maddr_q;
    assign mout  = mout_q;
    assign mre   = mre_q;
    assign mwe   = mwe_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with two ports and a simple memory model.
module tb_mem_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned WW = 64;
    localparam int unsigned NP = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP*AW-1:0] addr;
    logic [NP*WW-1:0] din, dout;
    logic [NP-1:0]   re, we, ready;
    logic [AW-1:0]   maddr;
    logic [WW-1:0]   mout, min;
    logic            mre, mwe, mready;

    mem_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .PORT_BITS(1)) dut (
        .clk(clk), .rst(rst), .addr(addr), .din(din), .dout(dout),
        .re(re), .we(we), .ready(ready), .maddr(maddr), .mout(mout),
        .min(min), .mre(mre), .mwe(mwe), .mready(mready)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rd_data(input logic [63:0] a);
        if (a == 64'h40) return 64'hDEAD;
        return (a << 1) + a + 64'h1111;
    endfunction

    // Memory model: read data registered one cycle after the mre pulse.
    always @(posedge clk) begin
        if (mre) min <= rd_data(maddr);
    end

    typedef struct packed {
        logic [31:0] port;
        logic        rd;
        logic [63:0] addr;
        logic [63:0] data;
    } gnt_t;

    gnt_t        gq[$];
    logic [63:0] cq0[$];
    logic [63:0] cq1[$];
    logic [63:0] last_rd [NP];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int p, input bit r, input bit w, input logic [63:0] a, input logic [63:0] d);
        re[p] = r;
        we[p] = w;
        addr[p*AW +: AW] = a;
        din[p*WW +: WW]  = d;
    endtask

    task automatic expect_req(input int p, input bit r, input bit w, input logic [63:0] a, input logic [63:0] d);
        gnt_t g;
        g.port = 32'(p);
        g.rd   = r;
        g.addr = a;
        g.data = d;
        if (r || w) begin
            gq.push_back(g);
            if (r) last_rd[p] = rd_data(a);
            if (p == 0) cq0.push_back(last_rd[p]);
            else        cq1.push_back(last_rd[p]);
        end
    endtask

    task automatic release_req();
        @(negedge clk);
        re = '0;
        we = '0;
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        while ((gq.size() != 0 || cq0.size() != 0 || cq1.size() != 0 || ready != '1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 300) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d grants, %0d/%0d completions outstanding, expected none",
                     name, gq.size(), cq0.size(), cq1.size());
            gq.delete();
            cq0.delete();
            cq1.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: compares every memory pulse and every ready rise against the queues.
    logic [NP-1:0] prev_ready = '1;
    always @(negedge clk) begin : mon
        gnt_t        g;
        logic [63:0] e;
        if (rst) begin
            prev_ready = ready;
        end else begin
            if (mre || mwe) begin
                if (gq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_grant: maddr=0x%0h mre=%0b mwe=%0b, expected no grant", maddr, mre, mwe);
                end else begin
                    g = gq.pop_front();
                    check("grant_mre", 64'(mre), 64'(g.rd));
                    check("grant_mwe", 64'(mwe), 64'(!g.rd));
                    check("grant_maddr", maddr, g.addr);
                    if (!g.rd) check("grant_mout", mout, g.data);
                    check("grant_port_busy", 64'(ready[g.port]), 64'h0);
                end
            end
            for (int i = 0; i < int'(NP); i++) begin
                if (ready[i] && !prev_ready[i]) begin
                    if ((i == 0 && cq0.size() == 0) || (i == 1 && cq1.size() == 0)) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_ready: port %0d rose with dout=0x%0h, expected no completion", i, dout[i*WW +: WW]);
                    end else begin
                        e = (i == 0) ? cq0.pop_front() : cq1.pop_front();
                        check(i == 0 ? "dout0" : "dout1", dout[i*WW +: WW], e);
                    end
                end
            end
            prev_ready = ready;
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish within cycle budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent [NP];
        int n;
        rst = 1'b1; re = '0; we = '0; addr = '0; din = '0; mready = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state, then idle for 10 cycles.
        check("rst_ready", 64'(ready), 64'h3);
        check("rst_mre", 64'(mre), 64'h0);
        check("rst_mwe", 64'(mwe), 64'h0);
        check("rst_dout0", dout[0 +: WW], 64'h0);
        check("rst_dout1", dout[WW +: WW], 64'h0);
        check("rst_maddr", maddr, 64'h0);
        check("rst_mout", mout, 64'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ready", 64'(ready), 64'h3);
            check("idle_mem", 64'({mre, mwe}), 64'h0);
        end

        // Port 0 read 0x40 with cycle-exact latency; second pulse while busy is ignored.
        drive(0, 1, 0, 64'h40, 64'h0);
        expect_req(0, 1, 0, 64'h40, 64'h0);
        @(negedge clk);
        check("lat_ready_low", 64'(ready[0]), 64'h0);
        check("lat_no_mre_t1", 64'(mre), 64'h0);
        drive(0, 1, 0, 64'h999, 64'h0);
        release_req();
        check("lat_no_mre_t2", 64'(mre), 64'h0);
        @(negedge clk);
        check("lat_mre_t3", 64'(mre), 64'h1);
        check("lat_maddr_t3", maddr, 64'h40);
        @(negedge clk);
        check("lat_busy_t4", 64'(ready[0]), 64'h0);
        @(negedge clk);
        check("lat_ready_t5", 64'(ready[0]), 64'h1);
        check("lat_dout_t5", dout[0 +: WW], 64'hDEAD);
        wait_quiet("read_p0");

        // Port 0 write: mwe with data, dout untouched.
        drive(0, 0, 1, 64'h20, 64'h5555);
        expect_req(0, 0, 1, 64'h20, 64'h5555);
        release_req();
        wait_quiet("write_p0");
        check("write_keeps_dout0", dout[0 +: WW], 64'hDEAD);

        // Port 1 re+we together: read wins.
        drive(1, 1, 1, 64'h80, 64'h1234);
        expect_req(1, 1, 1, 64'h80, 64'h1234);
        release_req();
        wait_quiet("rw_p1");
        check("rw_dout1", dout[WW +: WW], 64'h1291);

        // Both ports same cycle, pointer 0: port 0 then port 1.
        drive(0, 1, 0, 64'h100, 64'h0);
        drive(1, 1, 0, 64'h180, 64'h0);
        expect_req(0, 1, 0, 64'h100, 64'h0);
        expect_req(1, 1, 0, 64'h180, 64'h0);
        release_req();
        wait_quiet("both_ptr0");

        // Port 0 alone moves the pointer; then both together.
        drive(0, 1, 0, 64'h200, 64'h0);
        expect_req(0, 1, 0, 64'h200, 64'h0);
        release_req();
        wait_quiet("ptr_move");
        drive(0, 1, 0, 64'h208, 64'h0);
        drive(1, 1, 0, 64'h288, 64'h0);
`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
        expect_req(0, 1, 0, 64'h208, 64'h0);
        expect_req(1, 1, 0, 64'h288, 64'h0);
`else
        expect_req(1, 1, 0, 64'h288, 64'h0);
        expect_req(0, 1, 0, 64'h208, 64'h0);
`endif
        release_req();
        wait_quiet("both_ptr1");

        // Streaming: each port re-requests as soon as it is ready; 20 grants alternate.
        for (int k = 0; k < 20; k++) begin
            expect_req(k % 2, 1, 0, 64'h1000 + 64'(k % 2) * 64'h100 + 64'(k / 2) * 64'h8, 64'h0);
        end
        sent[0] = 0;
        sent[1] = 0;
        for (int cyc = 0; cyc < 600 && (sent[0] < 10 || sent[1] < 10); cyc++) begin
            re = '0;
            we = '0;
            for (int p = 0; p < int'(NP); p++) begin
                if (ready[p] && sent[p] < 10 && (p == 0 || cyc > 0)) begin
                    drive(p, 1, 0, 64'h1000 + 64'(p) * 64'h100 + 64'(sent[p]) * 64'h8, 64'h0);
                    sent[p]++;
                end
            end
            @(negedge clk);
        end
        re = '0;
        we = '0;
        wait_quiet("stream");

        // Reset during WAIT with memory not ready; nothing issues until mready returns.
        drive(0, 1, 0, 64'h300, 64'h0);
        expect_req(0, 1, 0, 64'h300, 64'h0);
        release_req();
        n = 0;
        while (!mre && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("midrst_saw_mre", 64'(mre), 64'h1);
        mready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cq0.delete();
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", 64'(ready), 64'h3);
        check("midrst_dout0", dout[0 +: WW], 64'h0);
        check("midrst_mre", 64'(mre), 64'h0);
        drive(1, 1, 0, 64'h500, 64'h0);
        release_req();
        for (int i = 0; i < 5; i++) begin
            check("hold_no_issue", 64'({mre, mwe}), 64'h0);
            check("hold_latched", 64'(ready[1]), 64'h0);
            @(negedge clk);
        end
        expect_req(1, 1, 0, 64'h500, 64'h0);
        mready = 1'b1;
        wait_quiet("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
